// File: rtl/line_buffer_3row.sv
// Three-row raster line buffer: emits vertically aligned 3-pixel columns.
// Optional LB_EDGE_ZERO_EN: outputs rows 0/1 with missing rows forced to 0.
module line_buffer_3row #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int          WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_done
);

    localparam int AW = (PIC_WIDTH > 11'd1) ? $clog2(int'(PIC_WIDTH)) : 1;

    logic [WIDTH-1:0] line0_mem [0:PIC_WIDTH-1];
    logic [WIDTH-1:0] line1_mem [0:PIC_WIDTH-1];

    logic [10:0]      col_cnt_q, col_cnt_d;
    logic [10:0]      row_cnt_q, row_cnt_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic [WIDTH-1:0] dout3_q, dout3_d;

    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
    logic             last_col;
    logic             last_row;

    assign addr     = col_cnt_q[AW-1:0];
    assign rd0      = line0_mem[addr];
    assign rd1      = line1_mem[addr];
    assign last_col = (col_cnt_q == PIC_WIDTH - 11'd1);
    assign last_row = (row_cnt_q == PIC_HEIGHT - 11'd1);

    // Line storage is never reset; stale rows are masked by row_cnt.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            line1_mem[addr] <= rd0;
            line0_mem[addr] <= din;
        end
    end

    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        dout1_d      = dout1_q;
        dout2_d      = dout2_q;
        dout3_d      = dout3_q;
        if (valid_in) begin
            dout3_d      = din;
            dout2_d      = rd0;
            dout1_d      = rd1;
            valid_out_d  = (row_cnt_q >= 11'd2);
            frame_done_d = last_col && last_row;
`ifdef LB_EDGE_ZERO_EN
            valid_out_d = 1'b1;
            if (row_cnt_q < 11'd2) begin
                dout1_d = '0;
            end
            if (row_cnt_q == 11'd0) begin
                dout2_d = '0;
            end
`endif
            if (last_col) begin
                col_cnt_d = 11'd0;
                row_cnt_d = last_row ? 11'd0 : row_cnt_q + 11'd1;
            end else begin
                col_cnt_d = col_cnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dout1_q      <= '0;
            dout2_q      <= '0;
            dout3_q      <= '0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            dout1_q      <= dout1_d;
            dout2_q      <= dout2_d;
            dout3_q      <= dout3_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign dout1      = dout1_q;
    assign dout2      = dout2_q;
    assign dout3      = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: directed frames plus random stream vs a
// pixel-history reference model (4x3 frame, 8-bit pixels).
module tb_line_buffer_3row;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] din = 8'h00;
    logic       valid_out;
    logic       frame_done;
    logic [7:0] dout1;
    logic [7:0] dout2;
    logic [7:0] dout3;

    int errors = 0;
    int checks = 0;

    logic [7:0] hist[$];
    int         k = 0;
    logic [7:0] e1 = 8'h00;
    logic [7:0] e2 = 8'h00;
    logic [7:0] e3 = 8'h00;
    bit         k1 = 1'b1;
    bit         k2 = 1'b1;
    bit         ev = 1'b0;
    bit         efd = 1'b0;

    line_buffer_3row #(
        .PIC_WIDTH (11'd4),
        .PIC_HEIGHT(11'd3),
        .WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_out", 8'(valid_out), 8'(ev));
        chk("frame_done", 8'(frame_done), 8'(efd));
        chk("dout3", dout3, e3);
        if (k2) chk("dout2", dout2, e2);
        if (k1) chk("dout1", dout1, e1);
    endtask

    // Model: column above = pixel W accepted earlier, two above = 2W earlier.
    task automatic step(input bit v, input logic [7:0] d);
        valid_in = v;
        din = d;
        @(posedge clk);
        #1;
        if (v) begin
            int r;
            int n;
            r = k / W;
            n = hist.size();
            ev = (r >= 2);
            efd = (k == W * H - 1);
            e3 = d;
            k2 = (n >= W);
            if (k2) e2 = hist[n-W];
            k1 = (n >= 2 * W);
            if (k1) e1 = hist[n-2*W];
`ifdef LB_EDGE_ZERO_EN
            ev = 1'b1;
            if (r < 2) begin
                e1 = 8'h00;
                k1 = 1'b1;
            end
            if (r == 0) begin
                e2 = 8'h00;
                k2 = 1'b1;
            end
`endif
            hist.push_back(d);
            k = (k + 1) % (W * H);
        end else begin
            ev = 1'b0;
            efd = 1'b0;
        end
        check_all();
    endtask

    task automatic feed(input int r, input int c);
        step(1'b1, 8'(r * 16 + c));
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 8'(valid_out), 8'd0);
        chk("rst_fd", 8'(frame_done), 8'd0);
        chk("rst_d1", dout1, 8'h00);
        chk("rst_d2", dout2, 8'h00);
        chk("rst_d3", dout3, 8'h00);
        hist.delete();
        k = 0;
        e1 = 8'h00;
        e2 = 8'h00;
        e3 = 8'h00;
        k1 = 1'b1;
        k2 = 1'b1;
        ev = 1'b0;
        efd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Reset in the middle of a line, then two lines stay masked
        feed(0, 0);
        feed(0, 1);
        feed(0, 2);
        do_reset();
        for (int i = 0; i < 8; i++) feed(i / W, i % W);
        feed(2, 0);
        feed(2, 1);
        chk("d3_21", dout3, 8'h21);
        chk("d2_21", dout2, 8'h11);
        chk("d1_21", dout1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hee);
            chk("stall_d3", dout3, 8'h21);
            chk("stall_d1", dout1, 8'h01);
        end
        feed(2, 2);
        chk("d3_22", dout3, 8'h22);
        chk("d2_22", dout2, 8'h12);
        chk("d1_22", dout1, 8'h02);
        feed(2, 3);
        chk("fd_23", 8'(frame_done), 8'd1);
        // Second frame: rows 0-1 masked, row 2 aligned
        for (int i = 0; i < W * H; i++) begin
            feed(i / W, i % W);
            if (i == 8) begin
                chk("f2_d3", dout3, 8'h20);
                chk("f2_d2", dout2, 8'h10);
                chk("f2_d1", dout1, 8'h00);
            end
        end
        // Reset after (1,2) of a third frame, then a clean frame
        for (int i = 0; i < 7; i++) feed(i / W, i % W);
        do_reset();
        for (int i = 0; i < W * H; i++) begin
            feed(i / W, i % W);
            if (i == 8) chk("rf_d3", dout3, 8'h20);
            if (i == 8) chk("rf_d2", dout2, 8'h10);
        end
`ifdef LB_EDGE_ZERO_EN
        do_reset();
        feed(0, 0);
        feed(0, 1);
        feed(0, 2);
        chk("ez_v", 8'(valid_out), 8'd1);
        chk("ez_d3", dout3, 8'h02);
        chk("ez_d2", dout2, 8'h00);
        chk("ez_d1", dout1, 8'h00);
        feed(0, 3);
        feed(1, 0);
        feed(1, 1);
        feed(1, 2);
        chk("ez_d3b", dout3, 8'h12);
        chk("ez_d2b", dout2, 8'h02);
        chk("ez_d1b", dout1, 8'h00);
`endif
        // Random data with random stalls across several frames
        do_reset();
        for (int i = 0; i < 4 * W * H; i++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
            step(1'b1, 8'($urandom));
        end
        step(1'b0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_buffer_3row.md
LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter PIC_WIDTH, default 11'd250, pixels per line (2..2047).
REQ-002 Parameter PIC_HEIGHT, default 11'd250, lines per frame (3..2047).
REQ-003 Parameter WIDTH, default 24, pixel data width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  din carries a valid raster-order pixel this cycle.
REQ-007 din  input  WIDTH  incoming pixel.
REQ-008 valid_out  output  1  dout1/2/3 hold a valid vertically aligned column.
REQ-009 dout1  output  WIDTH  pixel two lines above the current pixel (top row).
REQ-010 dout2  output  WIDTH  pixel one line above the current pixel (middle row).
REQ-011 dout3  output  WIDTH  current pixel (bottom row).
REQ-012 frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-013 The block shall store two full lines (2 x PIC_WIDTH x WIDTH) as line delays indexed by an 11-bit column counter col_cnt.
REQ-014 On each valid_in cycle: dout3<=din, dout2<=line0[col_cnt], dout1<=line1[col_cnt], line1[col_cnt]<=old line0[col_cnt], line0[col_cnt]<=din; latency exactly 1 clk.
REQ-015 col_cnt shall increment per valid_in, wrapping PIC_WIDTH-1 -> 0; the wrap shall increment an 11-bit row counter row_cnt.
REQ-016 With valid_in=1 at row_cnt>=2, valid_out shall be 1 the following cycle; otherwise valid_out shall be 0 the following cycle.
REQ-017 With valid_in=0, counters, line contents and dout1/2/3 shall hold; valid_out shall be 0 next cycle; stalls of any length anywhere in a line shall not misalign columns.
REQ-018 On the valid_in accepting pixel (PIC_HEIGHT-1, PIC_WIDTH-1): frame_done=1 next cycle for exactly one cycle; row_cnt and col_cnt shall return to 0.
REQ-019 After a frame wrap, rows 0 and 1 of the new frame shall produce valid_out=0 (stale lines masked, not cleared).
REQ-020 Line storage shall be either registers or inferred RAM; observable behaviour shall be identical.

Reset
REQ-021 rst_n low shall asynchronously set valid_out=0, frame_done=0, dout1=dout2=dout3=0, col_cnt=0, row_cnt=0.
REQ-022 Line contents need not be cleared; reset mid-frame shall restart at pixel (0,0) with the masking of REQ-019.

Configuration
REQ-023 Macro LB_EDGE_ZERO_EN: when defined, valid_out shall also assert for rows 0 and 1, with dout1 (rows 0,1) and dout2 (row 0) forced to 0 in place of stale line data.
REQ-024 Without LB_EDGE_ZERO_EN, behaviour shall be exactly REQ-016/REQ-019 and no zero-forcing logic shall be present.

Verification (PIC_WIDTH=4, PIC_HEIGHT=3, WIDTH=8, pixel value = row*16+col)
REQ-025 Reset asserted mid-stream -> all outputs 0 same cycle; after release, 8 pixels fed -> valid_out stays 0.
REQ-026 Continuous frame; input 0x21 at (2,1) -> next cycle valid_out=1, dout3=0x21, dout2=0x11, dout1=0x01.
REQ-027 valid_in low 3 cycles between (2,1) and (2,2) -> valid_out=0 for those cycles, outputs hold 0x21/0x11/0x01; on 0x22 -> 0x22/0x12/0x02.
REQ-028 Input (2,3)=0x23 -> next cycle frame_done=1 for one cycle; second frame rows 0-1 give valid_out=0; (2,0) gives 0x20/0x10/0x00.
REQ-029 Reset pulse after (1,2), then a full frame -> first valid_out at new (2,0) with 0x20/0x10/0x00.
REQ-030 LB_EDGE_ZERO_EN defined; input (0,2)=0x02 -> valid_out=1, dout3=0x02, dout2=0, dout1=0; (1,2)=0x12 -> 0x12/0x02/0.
